// File: rtl/sram_axi_bridge_pkg.sv
// sram_axi_bridge_pkg: shared FSM encodings and AXI constants for the SRAM-to-AXI bridge
package sram_axi_bridge_pkg;
  typedef enum logic [1:0] {RD_IDLE, RD_AR, RD_R} rd_state_e;
  typedef enum logic [1:0] {WR_IDLE, WR_AW_W, WR_B} wr_state_e;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [3:0] LEN_1 = 4'd0;
  localparam logic [2:0] SIZE_WORD = 3'b010;
  function automatic logic [2:0] axi_size(input logic [1:0] s);
    return {1'b0, s};
  endfunction
endpackage

// File: rtl/sram_axi_bridge_wr_chan.sv
// axi_wr_chan: single-beat AXI write FSM; AW and W retire independently, then wait for B
module axi_wr_chan
  import sram_axi_bridge_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [1:0]      size_i,
  input  logic [DW/8-1:0] wstrb_i,
  input  logic [DW-1:0]   wdata_i,
  output logic            idle_o,
  output logic            done_o,
  output logic [AW-1:0]   addr_o,
  output logic [2:0]      awsize_o,
  output logic            awvalid_o,
  input  logic            awready_i,
  output logic [DW-1:0]   wdata_o,
  output logic [DW/8-1:0] wstrb_o,
  output logic            wvalid_o,
  input  logic            wready_i,
  input  logic            bvalid_i,
  output logic            bready_o
);
  wr_state_e       st_q, st_d;
  logic            aw_done_q, aw_done_d, w_done_q, w_done_d, done_q;
  logic [AW-1:0]   addr_q;
  logic [1:0]      size_q;
  logic [DW/8-1:0] wstrb_q;
  logic [DW-1:0]   wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= WR_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      done_q    <= 1'b0;
      addr_q    <= '0;
      size_q    <= '0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
    end else begin
      st_q      <= st_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      done_q    <= bready_o && bvalid_i;
      if (start_i) begin
        addr_q  <= addr_i;
        size_q  <= size_i;
        wstrb_q <= wstrb_i;
        wdata_q <= wdata_i;
      end
    end
  end

  // done flags only live inside WR_AW_W, so they self-clear once the join completes
  always_comb begin
    aw_done_d = (st_q == WR_AW_W) && (aw_done_q || (awvalid_o && awready_i));
    w_done_d  = (st_q == WR_AW_W) && (w_done_q || (wvalid_o && wready_i));
    st_d = (st_q == WR_IDLE) ? (start_i ? WR_AW_W : WR_IDLE) :
           (st_q == WR_AW_W) ? ((aw_done_d && w_done_d) ? WR_B : WR_AW_W) :
           (bvalid_i ? WR_IDLE : WR_B);
  end

  always_comb begin
    awvalid_o = (st_q == WR_AW_W) && !aw_done_q;
    wvalid_o  = (st_q == WR_AW_W) && !w_done_q;
    bready_o  = (st_q == WR_B);
    idle_o    = (st_q == WR_IDLE);
    done_o    = done_q;
    addr_o    = addr_q;
    awsize_o  = axi_size(size_q);
    wstrb_o   = wstrb_q;
    wdata_o   = wdata_q;
  end
endmodule

// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: merges inst (read-only) and data SRAM-like ports onto one single-beat AXI3 master
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_sram_req,
  input  logic [AW-1:0]   inst_sram_addr,
  output logic            inst_sram_addr_ok,
  output logic            inst_sram_data_ok,
  output logic [DW-1:0]   inst_sram_rdata,
  input  logic            data_sram_req,
  input  logic            data_sram_wr,
  input  logic [1:0]      data_sram_size,
  input  logic [DW/8-1:0] data_sram_wstrb,
  input  logic [AW-1:0]   data_sram_addr,
  input  logic [DW-1:0]   data_sram_wdata,
  output logic            data_sram_addr_ok,
  output logic            data_sram_data_ok,
  output logic [DW-1:0]   data_sram_rdata,
  output logic [AW-1:0]   araddr,
  output logic [2:0]      arsize,
  output logic            arvalid,
  input  logic            arready,
  input  logic [DW-1:0]   rdata,
  input  logic            rvalid,
  output logic            rready,
  output logic [AW-1:0]   awaddr,
  output logic [2:0]      awsize,
  output logic            awvalid,
  input  logic            awready,
  output logic [DW-1:0]   wdata,
  output logic [DW/8-1:0] wstrb,
  output logic            wvalid,
  input  logic            wready,
  input  logic            bvalid,
  output logic            bready
);
  rd_state_e     rd_q, rd_d;
  logic [AW-1:0] araddr_q, wr_addr;
  logic [2:0]    arsize_q;
  logic          owner_q, rd_dok_q, data_busy_q;
  logic [DW-1:0] inst_rdata_q, data_rdata_q;
  logic          wr_idle, wr_dok, data_busy, raw_hit, data_rd_acc, inst_acc, wr_acc, r_hs;

  // data port is free again in the very cycle its data_ok pulses
  always_comb begin
    data_busy   = data_busy_q && !data_sram_data_ok;
    raw_hit     = !wr_idle && (data_sram_addr[AW-1:2] == wr_addr[AW-1:2]);
    data_rd_acc = (rd_q == RD_IDLE) && data_sram_req && !data_sram_wr && !data_busy && !raw_hit;
    inst_acc    = (rd_q == RD_IDLE) && inst_sram_req && !data_rd_acc;
    wr_acc      = wr_idle && data_sram_req && data_sram_wr && !data_busy;
    r_hs        = (rd_q == RD_R) && rvalid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q         <= RD_IDLE;
      araddr_q     <= '0;
      arsize_q     <= '0;
      owner_q      <= 1'b0;
      rd_dok_q     <= 1'b0;
      data_busy_q  <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      rd_q        <= rd_d;
      rd_dok_q    <= r_hs;
      data_busy_q <= data_sram_addr_ok || data_busy;
      if (data_rd_acc || inst_acc) begin
        araddr_q <= data_rd_acc ? data_sram_addr : inst_sram_addr;
        arsize_q <= data_rd_acc ? axi_size(data_sram_size) : SIZE_WORD;
        owner_q  <= data_rd_acc;
      end
      if (r_hs && owner_q) data_rdata_q <= rdata;
      if (r_hs && !owner_q) inst_rdata_q <= rdata;
    end
  end

  always_comb begin
    rd_d = (rd_q == RD_IDLE) ? ((data_rd_acc || inst_acc) ? RD_AR : RD_IDLE) :
           (rd_q == RD_AR)   ? (arready ? RD_R : RD_AR) :
           (rvalid ? RD_IDLE : RD_R);
  end

  always_comb begin
    arvalid           = (rd_q == RD_AR);
    rready            = (rd_q == RD_R);
    araddr            = araddr_q;
    arsize            = arsize_q;
    inst_sram_addr_ok = inst_acc;
    data_sram_addr_ok = data_rd_acc || wr_acc;
    inst_sram_data_ok = rd_dok_q && !owner_q;
    data_sram_data_ok = (rd_dok_q && owner_q) || wr_dok;
    inst_sram_rdata   = inst_rdata_q;
    data_sram_rdata   = data_rdata_q;
  end

  axi_wr_chan #(.AW(AW), .DW(DW)) u_wr (
    .clk       (clk),
    .rst       (rst),
    .start_i   (wr_acc),
    .addr_i    (data_sram_addr),
    .size_i    (data_sram_size),
    .wstrb_i   (data_sram_wstrb),
    .wdata_i   (data_sram_wdata),
    .idle_o    (wr_idle),
    .done_o    (wr_dok),
    .addr_o    (wr_addr),
    .awsize_o  (awsize),
    .awvalid_o (awvalid),
    .awready_i (awready),
    .wdata_o   (wdata),
    .wstrb_o   (wstrb),
    .wvalid_o  (wvalid),
    .wready_i  (wready),
    .bvalid_i  (bvalid),
    .bready_o  (bready)
  );
  assign awaddr = wr_addr;
endmodule

// File: tb/tb_sram_axi_bridge.sv
// tb_sram_axi_bridge: directed scoreboard bench for the SRAM-to-AXI bridge
module tb_sram_axi_bridge;
  logic        clk, rst;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [2:0]  arsize, awsize;
  logic [3:0]  wstrb;
  logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;

  typedef struct {bit wr; logic [31:0] d;} exp_t;
  logic [31:0] inst_q[$];
  exp_t        data_q[$];
  logic [31:0] ar_log[$];
  int          n_chk = 0, n_fail = 0, aw_cnt = 0, w_cnt = 0;
  logic [31:0] aw_addr_log, wdata_log;
  logic [3:0]  wstrb_log;
  logic [2:0]  awsize_log;

  sram_axi_bridge dut (
    .clk(clk), .rst(rst),
    .inst_sram_req(inst_req), .inst_sram_addr(inst_addr), .inst_sram_addr_ok(inst_addr_ok),
    .inst_sram_data_ok(inst_data_ok), .inst_sram_rdata(inst_rdata),
    .data_sram_req(data_req), .data_sram_wr(data_wr), .data_sram_size(data_size),
    .data_sram_wstrb(data_wstrb), .data_sram_addr(data_addr), .data_sram_wdata(data_wdata),
    .data_sram_addr_ok(data_addr_ok), .data_sram_data_ok(data_data_ok), .data_sram_rdata(data_rdata),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  // slave memory: one fixed word, everything else reads back a tagged copy of its address
  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return (a == 32'h1C000000) ? 32'h02800C0C : {16'hD00D, a[15:0]};
  endfunction
  assign rdata = rd_mem(araddr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_dok(input bit inst, input int lim, input string name);
    bit seen = 0;
    for (int i = 0; i < lim && !seen; i++) begin
      if (inst ? inst_data_ok : data_data_ok) seen = 1;
      else cyc();
    end
    chk(name, {31'd0, seen}, 32'd1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (inst_data_ok) begin
        if (inst_q.size() == 0) chk("inst_unexpected_dok", {31'd0, inst_data_ok}, 32'd0);
        else chk("inst_rdata", inst_rdata, inst_q.pop_front());
      end
      if (data_data_ok) begin
        if (data_q.size() == 0) chk("data_unexpected_dok", {31'd0, data_data_ok}, 32'd0);
        else begin
          e = data_q.pop_front();
          if (e.wr) chk("data_wr_resp", {31'd0, bready || !arvalid}, 32'd1);
          else chk("data_rdata", data_rdata, e.d);
        end
      end
      if (arvalid && arready) ar_log.push_back(araddr);
      if (awvalid && awready) begin
        aw_cnt++;
        aw_addr_log = awaddr;
        awsize_log  = awsize;
      end
      if (wvalid && wready) begin
        w_cnt++;
        wdata_log = wdata;
        wstrb_log = wstrb;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit got;
    rst = 1; inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0; data_size = 0;
    data_wstrb = 0; data_addr = 0; data_wdata = 0;
    arready = 1; rvalid = 1; awready = 1; wready = 1; bvalid = 1;
    repeat (3) cyc();
    rst = 0;
    cyc();
    chk("rst_arvalid", {31'd0, arvalid}, 0);
    chk("rst_awvalid", {31'd0, awvalid}, 0);
    chk("rst_wvalid", {31'd0, wvalid}, 0);
    chk("rst_rready", {31'd0, rready}, 0);
    chk("rst_bready", {31'd0, bready}, 0);
    chk("rst_dok", {30'd0, inst_data_ok, data_data_ok}, 0);
    chk("rst_inst_rdata", inst_rdata, 0);
    chk("rst_data_rdata", data_rdata, 0);
    // inst read with immediate slave: data_ok three cycles after the request
    inst_req = 1; inst_addr = 32'h1C000000; #1;
    chk("t1_addr_ok", {31'd0, inst_addr_ok}, 1);
    inst_q.push_back(32'h02800C0C);
    cyc(); inst_req = 0;
    chk("t1_arvalid", {31'd0, arvalid}, 1);
    chk("t1_araddr", araddr, 32'h1C000000);
    chk("t1_arsize", {29'd0, arsize}, 2);
    cyc();
    chk("t1_dok_c2", {31'd0, inst_data_ok}, 0);
    cyc();
    chk("t1_dok_c3", {31'd0, inst_data_ok}, 1);
    cyc();
    // data read beats inst read in the same cycle
    ar_log.delete();
    inst_req = 1; inst_addr = 32'h100;
    data_req = 1; data_wr = 0; data_addr = 32'h200; data_size = 2; #1;
    chk("t2_data_addr_ok", {31'd0, data_addr_ok}, 1);
    chk("t2_inst_addr_ok", {31'd0, inst_addr_ok}, 0);
    data_q.push_back('{0, 32'hD00D0200});
    inst_q.push_back(32'hD00D0100);
    cyc(); data_req = 0; #1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (inst_addr_ok) got = 1;
      cyc();
    end
    inst_req = 0;
    chk("t2_inst_retry", {31'd0, got}, 1);
    wait_dok(1, 10, "t2_inst_dok_timeout");
    cyc();
    chk("t2_ar_count", ar_log.size(), 2);
    chk("t2_ar_first", ar_log[0], 32'h200);
    chk("t2_ar_second", ar_log[1], 32'h100);
    // write with W accepted three cycles before AW
    awready = 0; wready = 1; bvalid = 1; aw_cnt = 0; w_cnt = 0;
    data_req = 1; data_wr = 1; data_addr = 32'h80; data_size = 1;
    data_wstrb = 4'b0011; data_wdata = 32'h1234ABCD; #1;
    chk("t3_addr_ok", {31'd0, data_addr_ok}, 1);
    data_q.push_back('{1, 32'd0});
    cyc(); data_req = 0; data_wr = 0;
    cyc(); cyc();
    chk("t3_awvalid_held", {30'd0, awvalid, wvalid}, 2);
    cyc(); awready = 1;
    wait_dok(0, 10, "t3_dok_timeout");
    cyc();
    chk("t3_aw_count", aw_cnt, 1);
    chk("t3_w_count", w_cnt, 1);
    chk("t3_awaddr", aw_addr_log, 32'h80);
    chk("t3_awsize", {29'd0, awsize_log}, 1);
    chk("t3_wstrb", {28'd0, wstrb_log}, 4'b0011);
    chk("t3_wdata", wdata_log, 32'h1234ABCD);
    // pending write blocks reads to the same word and to any other address
    bvalid = 0;
    data_req = 1; data_wr = 1; data_addr = 32'h40; data_size = 2;
    data_wstrb = 4'hF; data_wdata = 32'hCAFEF00D; #1;
    chk("t4_wr_addr_ok", {31'd0, data_addr_ok}, 1);
    data_q.push_back('{1, 32'd0});
    cyc(); data_wr = 0;
    for (int i = 0; i < 6; i++) begin
      data_addr = i[0] ? 32'h44 : 32'h40; #1;
      chk(i[0] ? "t4_rd44_refused" : "t4_rd40_refused", {31'd0, data_addr_ok}, 0);
      cyc();
    end
    data_req = 0; bvalid = 1;
    wait_dok(0, 10, "t4_wr_dok_timeout");
    cyc();
    data_req = 1; data_wr = 0; data_addr = 32'h40; #1;
    chk("t4_rd40_accepted", {31'd0, data_addr_ok}, 1);
    data_q.push_back('{0, 32'hD00D0040});
    cyc(); data_req = 0;
    wait_dok(0, 10, "t4_rd_dok_timeout");
    cyc();
    // AR stall, then reset in the middle of it
    arready = 0;
    inst_req = 1; inst_addr = 32'h300; #1;
    chk("t5_addr_ok", {31'd0, inst_addr_ok}, 1);
    cyc(); inst_req = 0;
    for (int i = 0; i < 6; i++) begin
      chk("t5_arvalid_stable", {31'd0, arvalid}, 1);
      chk("t5_araddr_stable", araddr, 32'h300);
      cyc();
    end
    rst = 1;
    cyc();
    rst = 0;
    chk("t5_rst_arvalid", {31'd0, arvalid}, 0);
    chk("t5_rst_inst_rdata", inst_rdata, 0);
    cyc();
    arready = 1;
    inst_req = 1; inst_addr = 32'h1C000000; #1;
    chk("t5_idle_addr_ok", {31'd0, inst_addr_ok}, 1);
    inst_q.push_back(32'h02800C0C);
    cyc(); inst_req = 0;
    wait_dok(1, 10, "t5_dok_timeout");
    cyc(); cyc();
    chk("inst_q_drained", inst_q.size(), 0);
    chk("data_q_drained", data_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
